// File: rtl/rotate_pkg.sv
// Shared types and constants for the LED rotator control path and the rotator itself.
package rotate_pkg;

    localparam int SPEED_W    = 2;
    localparam int NUM_SPEEDS = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [SPEED_W-1:0] speed_t;

    function automatic speed_t next_speed(input speed_t s);
        return speed_t'((32'(s) + 1) % NUM_SPEEDS);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One board button: 2-FF synchroniser, polarity normalisation, counter debounce,
// and single-cycle press/release pulses aligned with the first cycle of the new level.
module button_debounce
    import rotate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          BUT_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic but_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o
);

    localparam int              CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED_PIN = BUT_ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             level;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_q, release_q;

    assign level = sync2_q ^ BUT_ACTIVE_LOW;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (level != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= RELEASED_PIN;
            sync2_q   <= RELEASED_PIN;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= but_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= pressed_d & ~pressed_q;
            release_q <= ~pressed_d & pressed_q;
        end
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/rotate_ctrl.sv
// Button conditioning, direction/speed state and step prescaler for the LED rotator.
// Optional long-press pause on BUT[1] when ROTATE_CTRL_LONGPRESS_EN is defined.
module rotate_ctrl
    import rotate_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BASE_DIV        = 25_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter bit          BUT_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         but,
    output logic [1:0]         pressed,
    output logic               step,
    output logic               dir,
    output logic [SPEED_W-1:0] speed,
    output logic               paused
);

    localparam int PRESC_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    logic [1:0]         press_ev, release_ev;
    logic               speed_evt, pause_active;
    logic [PRESC_W-1:0] presc_q, presc_d, term_cnt;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    speed_t             speed_q, speed_d;
    logic               unused_ok;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BUT_ACTIVE_LOW (BUT_ACTIVE_LOW)
    ) u_but0 (
        .clk      (clk),
        .rst      (rst),
        .but_i    (but[0]),
        .pressed_o(pressed[0]),
        .press_o  (press_ev[0]),
        .release_o(release_ev[0])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BUT_ACTIVE_LOW (BUT_ACTIVE_LOW)
    ) u_but1 (
        .clk      (clk),
        .rst      (rst),
        .but_i    (but[1]),
        .pressed_o(pressed[1]),
        .press_o  (press_ev[1]),
        .release_o(release_ev[1])
    );

`ifdef ROTATE_CTRL_LONGPRESS_EN
    localparam int               LONG_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              paused_q, paused_d;

    // The hold counter stops once the long press has fired, so one hold toggles pause only once.
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        paused_d    = paused_q;
        if (!pressed[1]) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (!long_done_q) begin
            if (long_cnt_q == LONG_LAST) begin
                paused_d    = ~paused_q;
                long_done_d = 1'b1;
            end else begin
                long_cnt_d = long_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            paused_q    <= paused_d;
        end
    end

    // long_done_q is still set during the release pulse cycle, which suppresses the speed step.
    assign speed_evt    = release_ev[1] & ~long_done_q;
    assign pause_active = paused_q;
    assign unused_ok    = &{1'b0, press_ev[1], release_ev[0]};
`else
    assign speed_evt    = press_ev[1];
    assign pause_active = 1'b0;
    assign unused_ok    = &{1'b0, release_ev, LONG_CYCLES[0]};
`endif

    assign term_cnt = PRESC_W'((BASE_DIV >> speed_q) - 1);

    // A speed change restarts the period from zero and swallows a coincident terminal count.
    always_comb begin
        presc_d = presc_q + 1'b1;
        step_d  = 1'b0;
        if (speed_evt || pause_active) begin
            presc_d = '0;
        end else if (presc_q == term_cnt) begin
            presc_d = '0;
            step_d  = 1'b1;
        end
        speed_d = speed_evt ? next_speed(speed_q) : speed_q;
        dir_d   = dir_q ^ press_ev[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= DIR_LEFT;
            speed_q <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign speed  = speed_q;
    assign paused = pause_active;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Self-checking bench for rotate_ctrl: directed scenarios plus random button activity,
// all outputs compared every cycle against a schedule-based reference model.
module tb_rotate_ctrl;

    localparam int D     = 4;
    localparam int BASE  = 16;
    localparam int LONG  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] but = 2'b11;
    logic [1:0] pressed;
    logic       step;
    logic       dir;
    logic [1:0] speed;
    logic       paused;

    always #5 clk = ~clk;

    rotate_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BASE_DIV       (BASE),
        .LONG_CYCLES    (LONG),
        .BUT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .but    (but),
        .pressed(pressed),
        .step   (step),
        .dir    (dir),
        .speed  (speed),
        .paused (paused)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int period(input int s);
        return BASE >> s;
    endfunction

    // Reference model: debounce as "last D synced samples all disagree with the accepted level",
    // steps as an absolute schedule of edge numbers.
    bit       m_valid = 1'b0;
    bit [1:0] m_p1, m_p2;
    bit       m_hist [2][D];
    bit [1:0] m_pressed, m_pe, m_re;
    bit       m_dir, m_step, m_paused, m_done;
    int       m_speed, m_next_step, m_rise1;

    always @(posedge clk) begin : ref_model
        bit [1:0] pr_old, pe_old, re_old;
        bit       pa_old, done_old, sp_evt, lvl, all_diff;
        cyc++;
        if (!rst) begin
            m_valid   = 1'b1;
            m_p1      = 2'b11;
            m_p2      = 2'b11;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < D; j++) m_hist[i][j] = 1'b0;
            m_pressed = '0;
            m_pe      = '0;
            m_re      = '0;
            m_dir     = 1'b0;
            m_speed   = 0;
            m_step    = 1'b0;
            m_paused  = 1'b0;
            m_done    = 1'b0;
            m_rise1   = 0;
            m_next_step = cyc + period(0);
        end else begin
            pr_old   = m_pressed;
            pe_old   = m_pe;
            re_old   = m_re;
            pa_old   = m_paused;
            done_old = m_done;
            for (int i = 0; i < 2; i++) begin
                lvl = ~m_p2[i];
                for (int j = D - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = lvl;
                if (lvl != pr_old[i]) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++) if (m_hist[i][j] != lvl) all_diff = 1'b0;
                    if (all_diff) m_pressed[i] = lvl;
                end
            end
            m_pe = m_pressed & ~pr_old;
            m_re = ~m_pressed & pr_old;
            if (m_pe[1]) m_rise1 = cyc;
            m_p2 = m_p1;
            m_p1 = but;
            m_dir ^= pe_old[0];
`ifdef ROTATE_CTRL_LONGPRESS_EN
            sp_evt = re_old[1] && !done_old;
            if (pr_old[1] && !done_old && cyc == m_rise1 + LONG) begin
                m_paused = ~m_paused;
                m_done   = 1'b1;
            end
            if (!pr_old[1]) m_done = 1'b0;
`else
            sp_evt = pe_old[1];
`endif
            if (sp_evt) begin
                m_speed     = (m_speed + 1) % 4;
                m_step      = 1'b0;
                m_next_step = cyc + period(m_speed);
            end else if (pa_old) begin
                m_step      = 1'b0;
                m_next_step = cyc + period(m_speed);
            end else if (cyc == m_next_step) begin
                m_step      = 1'b1;
                m_next_step = cyc + period(m_speed);
            end else begin
                m_step = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("pressed", pressed, m_pressed);
            check("step",    step,    m_step);
            check("dir",     dir,     m_dir);
            check("speed",   speed,   m_speed);
            check("paused",  paused,  m_paused);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, t, sp, found;
        int stimes[$];

        // 1: reset and free-running steps at speed 0
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        r0  = cyc;
        check("rst_pressed", pressed, 0);
        check("rst_step",    step,    0);
        check("rst_dir",     dir,     0);
        check("rst_speed",   speed,   0);
        check("rst_paused",  paused,  0);
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (step === 1'b1) stimes.push_back(cyc - r0);
        end
        check("t1_nsteps", stimes.size(), 3);
        for (int j = 0; j < 3; j++)
            if (stimes.size() > j) check("t1_step_at", stimes[j], 16 * (j + 1));

        // 2: bouncing BUT[0] then a clean hold
        for (int k = 0; k < 10; k++) begin
            but[0] = ~but[0];
            tick(2);
        end
        but[0] = 1'b0;
        tick(2 + D);
        check("t2_dir_hold", dir, 0);
        tick(1);
        check("t2_dir_toggle", dir, 1);
        but[0] = 1'b1;
        tick(12);

        // 3: speed wrap through four clean presses
        for (int s = 1; s <= 4; s++) begin
            but[1] = 1'b0;
            tick(8);
            but[1] = 1'b1;
            tick(40);
            check("t3_speed", speed, s % 4);
        end

        // 4: speed event lands on a terminal-count cycle
        sp = speed;
`ifdef ROTATE_CTRL_LONGPRESS_EN
        but[1] = 1'b0;
        tick(10);
`endif
        found = 0;
        for (int k = 0; k < 64; k++) begin
            if (m_next_step == cyc + 3 + D) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check("t4_aligned", found, 1);
`ifdef ROTATE_CTRL_LONGPRESS_EN
        but[1] = 1'b1;
`else
        but[1] = 1'b0;
`endif
        tick(3 + D);
        check("t4_no_step", step, 0);
        check("t4_speed", speed, (sp + 1) % 4);
        tick(period((sp + 1) % 4) - 1);
        check("t4_early", step, 0);
        tick(1);
        check("t4_new_period", step, 1);
        but[1] = 1'b1;
        tick(20);

        // 5: reset mid-run with dir=1, speed=2 and BUT[1] held
        but[1] = 1'b0;
        tick(D + 8);
        check("t5_pre_dir", dir, 1);
`ifdef ROTATE_CTRL_LONGPRESS_EN
        check("t5_pre_speed", speed, 1);
`else
        check("t5_pre_speed", speed, 2);
`endif
        rst = 1'b0;
        tick(1);
        r0  = cyc;
        rst = 1'b1;
        check("t5_pressed", pressed, 0);
        check("t5_step",    step,    0);
        check("t5_dir",     dir,     0);
        check("t5_speed",   speed,   0);
        check("t5_paused",  paused,  0);
        tick(1 + D);
        check("t5_requal_early", pressed[1], 0);
        tick(1);
        check("t5_requal", pressed[1], 1);
        but[1] = 1'b1;
        tick(20);

`ifdef ROTATE_CTRL_LONGPRESS_EN
        // 6: long press toggles pause, short press steps speed on release
        sp = speed;
        but[1] = 1'b0;
        tick(40);
        check("t6_paused_on", paused, 1);
        but[1] = 1'b1;
        tick(D + 6);
        check("t6_paused_keep", paused, 1);
        check("t6_speed_keep", speed, sp);
        but[1] = 1'b0;
        tick(40);
        but[1] = 1'b1;
        tick(D + 6);
        check("t6_paused_off", paused, 0);
        check("t6_speed_keep2", speed, sp);
        but[1] = 1'b0;
        tick(10);
        but[1] = 1'b1;
        tick(2 + D);
        check("t6_short_before", speed, sp);
        tick(1);
        check("t6_short_after", speed, (sp + 1) % 4);
        tick(10);
`endif

        // random button activity, occasional bounces, dual presses and resets
        for (int it = 0; it < 40; it++) begin
            int i, hold;
            i = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b0;
                tick(1);
                rst = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 8)) begin
                    but[i] = ~but[i];
                    tick($urandom_range(1, 3));
                end
            end
            but[i] = 1'b0;
            if ($urandom_range(0, 4) == 0) but[1 - i] = 1'b0;
            hold = $urandom_range(1, 12);
`ifdef ROTATE_CTRL_LONGPRESS_EN
            if ($urandom_range(0, 4) == 0) hold = $urandom_range(30, 45);
`endif
            tick(hold);
            but = 2'b11;
            tick($urandom_range(1, 20));
        end
        tick(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
